// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO write arbiter slice.
//   DEFAULT_FIFO_WIDTH : default data width of requester words / FIFO port
//   DEFAULT_FIFO_DEPTH : depth of the FIFO this arbiter writes into
//   DEFAULT_NUM_REQ    : default number of producers (legal range 2..8)
//   CNT_W              : width of the retry and write counters
//   state_t            : controller state encoding (IDLE, WRITE, ACK)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int CNT_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer-side and FIFO-side signals of the write arbiter.
//
// Handshake: a producer raises req[i] with its word on req_data and holds
// both until done[i] pulses for one cycle; the word is captured when the grant
// is issued, so a producer may drop req afterwards and its write still
// completes. Towards the FIFO, fifo_wr_en is a single-cycle strobe and the
// FIFO answers in the following cycle with fifo_wr_ack (accepted) or
// fifo_overflow (rejected, will be retried); ack wins if both are high.
//
// Modports:
//   slave  : the arbiter (drives gnt/done/FIFO write side/status)
//   master : the environment (producers + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [CNT_W-1:0]              retry_cnt;
  logic [CNT_W-1:0]              wr_count;
  logic                          proto_err;

  modport slave (
    input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output gnt, done, fifo_wr_en, fifo_data_in, retry_cnt, wr_count, proto_err
  );

  modport master (
    output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  gnt, done, fifo_wr_en, fifo_data_in, retry_cnt, wr_count, proto_err
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector: grants the first requesting index at or
// after i_ptr, wrapping modulo NUM_REQ.
//   i_req   : request vector
//   i_ptr   : round-robin start index (must be < NUM_REQ)
//   o_gnt   : one-hot grant (zero when nothing requests)
//   o_valid : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);

  logic [NUM_REQ-1:0] w_rot_req;
  logic [NUM_REQ-1:0] w_rot_gnt;

  // Rotate right so the pointer position lands on bit 0; then the lowest set
  // bit is the winner. Rotating the one-hot back left restores its index.
  assign w_rot_req = NUM_REQ'({i_req, i_req} >> i_ptr);
  assign w_rot_gnt = w_rot_req & (~w_rot_req + NUM_REQ'(1));
  assign o_gnt     = NUM_REQ'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> NUM_REQ);
  assign o_valid   = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one FIFO write port among NUM_REQ producers. A Moore FSM
// (IDLE -> WRITE -> ACK) issues one write per three cycles, retries a write
// the FIFO rejected with overflow, and flags a missing FIFO response.
//
// Ports:
//   clk     : single clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : fifo_wr_arbiter_if.slave (req/req_data/gnt/done, FIFO write
//             port and status, retry_cnt, wr_count, proto_err)
//   o_state : current controller state, for observation
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.slave     bus,
  output state_t               o_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                r_state,  w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt,    w_gnt_nxt;
  logic [NUM_REQ-1:0]    r_done,   w_done_nxt;
  logic [IDX_W-1:0]      r_ptr,    w_ptr_nxt;
  logic [FIFO_WIDTH-1:0] r_data,   w_data_nxt;
  logic [CNT_W-1:0]      r_retry,  w_retry_nxt;
  logic [CNT_W-1:0]      r_wrc,    w_wrc_nxt;
  logic                  r_perr,   w_perr_nxt;

  logic [NUM_REQ-1:0]    w_rr_gnt;
  logic                  w_rr_valid;
  logic [NUM_REQ-1:0]    w_load_gnt;
  logic [FIFO_WIDTH-1:0] w_sel_data;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W-1:0]      w_ptr_after;
  logic                  w_retry_pend;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (IDX_W)
  ) u_rr (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_valid (w_rr_valid)
  );

  // A grant still held in IDLE can only come from an overflow; that
  // requester is re-served ahead of the round-robin choice.
  assign w_retry_pend = |r_gnt;
  assign w_load_gnt   = w_retry_pend ? r_gnt : w_rr_gnt;

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_load_gnt[k]) w_sel_data = bus.req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_gnt[k]) w_gnt_idx = IDX_W'(k);
    end
  end

  assign w_ptr_after = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_ptr_nxt   = r_ptr;
    w_data_nxt  = r_data;
    w_retry_nxt = r_retry;
    w_wrc_nxt   = r_wrc;
    w_perr_nxt  = r_perr;

    unique case (r_state)
      ST_IDLE: begin
        if (!bus.fifo_full && (w_retry_pend || w_rr_valid)) begin
          w_state_nxt = ST_WRITE;
          w_gnt_nxt   = w_load_gnt;
          w_data_nxt  = w_sel_data;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        if (bus.fifo_wr_ack) begin
          w_done_nxt = r_gnt;
          w_wrc_nxt  = r_wrc + CNT_W'(1);
          w_ptr_nxt  = w_ptr_after;
          w_gnt_nxt  = '0;
        end else if (bus.fifo_overflow) begin
          w_retry_nxt = r_retry + CNT_W'(1);
        end else begin
          w_perr_nxt = 1'b1;
          w_gnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_retry <= '0;
      r_wrc   <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_ptr   <= w_ptr_nxt;
      r_data  <= w_data_nxt;
      r_retry <= w_retry_nxt;
      r_wrc   <= w_wrc_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.done         = r_done;
  assign bus.fifo_wr_en   = (r_state == ST_WRITE);
  assign bus.fifo_data_in = r_data;
  assign bus.retry_cnt    = r_retry;
  assign bus.wr_count     = r_wrc;
  assign bus.proto_err    = r_perr;
  assign o_state          = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (FIFO_WIDTH=16, NUM_REQ=4).
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();
  state_t state_dbg;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .o_state (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int           m_ptr;
  int           m_pend;   // requester awaiting retry, -1 if none
  int           m_retry;
  int           m_wrc;
  bit           m_perr;
  logic [W-1:0] m_word [N];
  logic [W-1:0] exp_q [$];

  function automatic int m_pick(input logic [N-1:0] mask);
    if (m_pend >= 0) return m_pend;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_finish(input int g, input int resp);
    if (resp % 2 == 1) begin
      m_wrc  = (m_wrc + 1) % 256;
      m_ptr  = (g + 1) % N;
      m_pend = -1;
    end else if (resp == 2) begin
      m_retry = (m_retry + 1) % 256;
      m_pend  = g;
    end else begin
      m_perr = 1'b1;
      m_pend = -1;
    end
  endtask

  // ---------------- driver tasks ----------------
  typedef struct {
    logic         wr_en_w;
    logic [N-1:0] gnt_w;
    logic [W-1:0] data_w;
    logic         wr_en_a;
    logic [N-1:0] done_d;
    logic [N-1:0] gnt_d;
    logic         wr_en_d;
    logic [7:0]   retry_d;
    logic [7:0]   wrc_d;
    logic         perr_d;
    int           done_cycle;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_wr_ack = 1'b0;
    bus.fifo_overflow = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_ptr = 0; m_pend = -1; m_retry = 0; m_wrc = 0; m_perr = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_words(input bit rnd);
    for (int k = 0; k < N; k++) begin
      m_word[k] = rnd ? W'($urandom_range(0, 65535)) : W'(16'h1000 + k);
      bus.req_data[k*W +: W] = m_word[k];
    end
  endtask

  // One full arbitration: IDLE edge -> WRITE -> ACK (FIFO answers) -> result.
  // resp: 0 none, 1 ack, 2 overflow, 3 ack+overflow
  task automatic drive_txn(input logic [N-1:0] mask, input int resp,
                           input bit scramble, output obs_t o);
    bus.req = mask;
    bus.fifo_full = 1'b0;
    step();
    o.wr_en_w = bus.fifo_wr_en;
    o.gnt_w   = bus.gnt;
    o.data_w  = bus.fifo_data_in;
    if (scramble) begin
      bus.req = N'($urandom_range(0, 15));
      bus.req_data = {$urandom, $urandom};
    end
    step();
    o.wr_en_a = bus.fifo_wr_en;
    bus.fifo_wr_ack   = (resp % 2 == 1);
    bus.fifo_overflow = (resp >= 2);
    step();
    bus.fifo_wr_ack   = 1'b0;
    bus.fifo_overflow = 1'b0;
    o.done_d  = bus.done;
    o.gnt_d   = bus.gnt;
    o.wr_en_d = bus.fifo_wr_en;
    o.retry_d = bus.retry_cnt;
    o.wrc_d   = bus.wr_count;
    o.perr_d  = bus.proto_err;
    o.done_cycle = cycle;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.req_data = {$urandom, $urandom};
    bus.fifo_full = 1'b0;
    bus.fifo_wr_ack = 1'b1;
    bus.fifo_overflow = 1'b1;
    step();
    step();
    checks++;
    if ({bus.gnt, bus.done, bus.fifo_wr_en, bus.fifo_data_in, bus.retry_cnt,
         bus.wr_count, bus.proto_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%h done=%h wr_en=%b data=%h retry=%0d wrc=%0d perr=%b expected all zero",
               bus.gnt, bus.done, bus.fifo_wr_en, bus.fifo_data_in, bus.retry_cnt, bus.wr_count, bus.proto_err);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    obs_t o;
    int   c0;
    do_reset();
    set_words(1'b0);
    m_word[0] = 16'hA5A5;
    bus.req_data[0 +: W] = 16'hA5A5;
    c0 = cycle;
    drive_txn(4'b0001, 1, 1'b0, o);
    checks++;
    if (o.wr_en_w !== 1'b1 || o.data_w !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_write_port: got wr_en=%b data=%h expected wr_en=1 data=a5a5", o.wr_en_w, o.data_w);
    end
    checks++;
    if (o.wr_en_a !== 1'b0 || o.wr_en_d !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_en_width: got ack=%b after=%b expected 0 0", o.wr_en_a, o.wr_en_d);
    end
    checks++;
    if (o.done_d !== 4'b0001 || (o.done_cycle - c0) != 3) begin
      errors++;
      $display("FAIL single_done: got done=%b latency=%0d expected done=0001 latency=3", o.done_d, o.done_cycle - c0);
    end
    checks++;
    if (o.wrc_d !== 8'd1 || o.gnt_d !== 4'b0000) begin
      errors++;
      $display("FAIL single_count: got wrc=%0d gnt=%b expected wrc=1 gnt=0000", o.wrc_d, o.gnt_d);
    end
    bus.req = '0;
    step();
    checks++;
    if (bus.done !== 4'b0000 || bus.fifo_wr_en !== 1'b0 || bus.fifo_data_in !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_after: got done=%b wr_en=%b data=%h expected done=0000 wr_en=0 data=a5a5",
               bus.done, bus.fifo_wr_en, bus.fifo_data_in);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    int   order [5] = '{0, 1, 2, 3, 0};
    int   prev = 0;
    do_reset();
    set_words(1'b0);
    for (int t = 0; t < 5; t++) begin
      logic [N-1:0] exp_oh;
      exp_oh = N'(1) << order[t];
      drive_txn(4'b1111, 1, 1'b0, o);
      checks++;
      if (o.gnt_w !== exp_oh || o.data_w !== m_word[order[t]] || o.done_d !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant_%0d: got gnt=%b data=%h done=%b expected gnt=%b data=%h done=%b",
                 t, o.gnt_w, o.data_w, o.done_d, exp_oh, m_word[order[t]], exp_oh);
      end
      if (t > 0) begin
        checks++;
        if (o.done_cycle - prev != 3) begin
          errors++;
          $display("FAIL rr_spacing_%0d: got %0d cycles expected 3", t, o.done_cycle - prev);
        end
      end
      prev = o.done_cycle;
    end
    bus.req = '0;
  endtask

  task automatic test_overflow_retry();
    obs_t o;
    do_reset();
    set_words(1'b0);
    drive_txn(4'b0100, 2, 1'b0, o);
    checks++;
    if (o.gnt_w !== 4'b0100 || o.done_d !== 4'b0000 || o.retry_d !== 8'd1 ||
        o.gnt_d !== 4'b0100 || o.wrc_d !== 8'd0) begin
      errors++;
      $display("FAIL ovf_result: got gnt_w=%b done=%b retry=%0d gnt=%b wrc=%0d expected 0100 0000 1 0100 0",
               o.gnt_w, o.done_d, o.retry_d, o.gnt_d, o.wrc_d);
    end
    bus.req = 4'b1100;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.fifo_wr_en !== 1'b0 || bus.retry_cnt !== 8'd1) begin
        errors++;
        $display("FAIL ovf_full_hold_%0d: got wr_en=%b retry=%0d expected 0 1", i, bus.fifo_wr_en, bus.retry_cnt);
      end
    end
    drive_txn(4'b1100, 1, 1'b0, o);
    checks++;
    if (o.gnt_w !== 4'b0100 || o.done_d !== 4'b0100 || o.data_w !== m_word[2]) begin
      errors++;
      $display("FAIL ovf_regrant: got gnt=%b done=%b data=%h expected 0100 0100 %h", o.gnt_w, o.done_d, o.data_w, m_word[2]);
    end
    drive_txn(4'b1000, 1, 1'b0, o);
    checks++;
    if (o.gnt_w !== 4'b1000 || o.done_d !== 4'b1000) begin
      errors++;
      $display("FAIL ovf_next: got gnt=%b done=%b expected 1000 1000", o.gnt_w, o.done_d);
    end
    drive_txn(4'b0001, 3, 1'b0, o);
    checks++;
    if (o.done_d !== 4'b0001 || o.retry_d !== 8'd1 || o.wrc_d !== 8'd3 || o.gnt_d !== 4'b0000) begin
      errors++;
      $display("FAIL ack_precedence: got done=%b retry=%0d wrc=%0d gnt=%b expected 0001 1 3 0000",
               o.done_d, o.retry_d, o.wrc_d, o.gnt_d);
    end
    bus.req = '0;
  endtask

  task automatic test_full_block();
    do_reset();
    bus.fifo_full = 1'b1;
    bus.req = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({bus.fifo_wr_en, bus.gnt, bus.done, bus.retry_cnt, bus.wr_count, bus.proto_err} !== '0) begin
        errors++;
        $display("FAIL full_block_%0d: got wr_en=%b gnt=%b done=%b retry=%0d wrc=%0d perr=%b expected all zero",
                 i, bus.fifo_wr_en, bus.gnt, bus.done, bus.retry_cnt, bus.wr_count, bus.proto_err);
      end
    end
    bus.fifo_full = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_proto_err();
    obs_t o;
    do_reset();
    set_words(1'b0);
    drive_txn(4'b0010, 0, 1'b0, o);
    checks++;
    if (o.perr_d !== 1'b1 || o.done_d !== 4'b0000 || o.gnt_d !== 4'b0000 || o.wrc_d !== 8'd0) begin
      errors++;
      $display("FAIL perr_set: got perr=%b done=%b gnt=%b wrc=%0d expected 1 0000 0000 0",
               o.perr_d, o.done_d, o.gnt_d, o.wrc_d);
    end
    // pointer did not advance, so requester 0 wins over 1
    drive_txn(4'b0011, 1, 1'b0, o);
    checks++;
    if (o.gnt_w !== 4'b0001 || o.perr_d !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: got gnt=%b perr=%b expected 0001 1", o.gnt_w, o.perr_d);
    end
    bus.req = '0;
    do_reset();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL perr_clear: got %b expected 0", bus.proto_err);
    end
  endtask

  task automatic test_reset_in_ack();
    do_reset();
    set_words(1'b0);
    bus.req = 4'b0010;
    step();
    checks++;
    if (bus.fifo_wr_en !== 1'b1 || bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rst_ack_write: got wr_en=%b gnt=%b expected 1 0010", bus.fifo_wr_en, bus.gnt);
    end
    step();
    bus.fifo_wr_ack = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if ({bus.gnt, bus.done, bus.fifo_wr_en, bus.fifo_data_in, bus.retry_cnt,
         bus.wr_count, bus.proto_err} !== '0) begin
      errors++;
      $display("FAIL rst_ack_outputs: got gnt=%b done=%b wr_en=%b data=%h retry=%0d wrc=%0d perr=%b expected all zero",
               bus.gnt, bus.done, bus.fifo_wr_en, bus.fifo_data_in, bus.retry_cnt, bus.wr_count, bus.proto_err);
    end
    rst = 1'b0;
    bus.fifo_wr_ack = 1'b0;
    bus.req = '0;
    step();
    checks++;
    if (bus.done !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ack_no_done: got %b expected 0000", bus.done);
    end
    do_reset();
  endtask

  task automatic test_random();
    obs_t o;
    do_reset();
    for (int it = 0; it < 250; it++) begin
      logic [N-1:0] mask;
      int           resp;
      int           g;
      bit           full;
      logic [N-1:0] exp_oh;
      mask = N'($urandom_range(0, 15));
      resp = $urandom_range(0, 3);
      full = ($urandom_range(0, 4) == 0);
      set_words(1'b1);
      g = m_pick(mask);
      if (full || g < 0) begin
        bus.req = mask;
        bus.fifo_full = full;
        step();
        exp_oh = (m_pend >= 0) ? (N'(1) << m_pend) : '0;
        checks++;
        if (bus.fifo_wr_en !== 1'b0 || bus.gnt !== exp_oh) begin
          errors++;
          $display("FAIL rand_idle_%0d: got wr_en=%b gnt=%b expected 0 %b", it, bus.fifo_wr_en, bus.gnt, exp_oh);
        end
        bus.fifo_full = 1'b0;
      end else begin
        logic [W-1:0] exp_data;
        exp_q.push_back(m_word[g]);
        drive_txn(mask, resp, 1'b1, o);
        exp_oh   = N'(1) << g;
        exp_data = exp_q.pop_front();
        checks++;
        if (o.wr_en_w !== 1'b1 || o.gnt_w !== exp_oh || o.data_w !== exp_data) begin
          errors++;
          $display("FAIL rand_write_%0d: got wr_en=%b gnt=%b data=%h expected 1 %b %h",
                   it, o.wr_en_w, o.gnt_w, o.data_w, exp_oh, exp_data);
        end
        m_finish(g, resp);
        checks++;
        if (o.done_d !== ((resp % 2 == 1) ? exp_oh : '0) ||
            o.gnt_d  !== ((resp == 2) ? exp_oh : '0) ||
            o.retry_d !== 8'(m_retry) || o.wrc_d !== 8'(m_wrc) || o.perr_d !== m_perr) begin
          errors++;
          $display("FAIL rand_result_%0d: got done=%b gnt=%b retry=%0d wrc=%0d perr=%b expected resp=%0d g=%0d retry=%0d wrc=%0d perr=%b",
                   it, o.done_d, o.gnt_d, o.retry_d, o.wrc_d, o.perr_d, resp, g, m_retry, m_wrc, m_perr);
        end
      end
    end
    bus.req = '0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_wr_ack = 1'b0;
    bus.fifo_overflow = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_overflow_retry();
    test_full_block();
    test_proto_err();
    test_reset_in_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
